// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: stall-cause encoding
// and default geometry (register-address width, writeback latency, counter width).
package hazard_pkg;

  localparam int AW_DEF     = 5;
  localparam int WB_LAT_DEF = 3;
  localparam int CW_DEF     = 16;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_BRANCH   = 2'd2,
    CAUSE_JR       = 2'd3
  } stall_cause_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the pending result lands in
// the register file, plus a flag marking that the pending producer is a load.
module hazard_sb_entry #(
  parameter int WB_LAT = hazard_pkg::WB_LAT_DEF,
  parameter int CNTW   = $clog2(WB_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            load_ld,
  output logic [CNTW-1:0] cnt,
  output logic            ld
);

  localparam logic [CNTW-1:0] LAT = CNTW'(WB_LAT);

  // NOTE: non-blocking assignments, so every entry updates from pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ld  <= 1'b0;
    end else if (load) begin
      // A reload on a still-busy register (WAW) wins over the countdown.
      cnt <= LAT;
      ld  <= load_ld;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNTW'(1)) ld <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls on load-use, branch-operand and jr-operand
// hazards. Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int WB_LAT = WB_LAT_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_branch,
  input  logic          id_jr,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wr_addr,
  input  logic          id_is_load,
  input  logic          id_flush,
  output logic          stall,
  output logic [1:0]    stall_cause,
  output logic [CW-1:0] perf_stall_cnt
);

  localparam int NREG = 2 ** AW;
  localparam int CNTW = $clog2(WB_LAT + 1);
  localparam logic [CNTW-1:0] LAT = CNTW'(WB_LAT);

  logic [NREG-1:0][CNTW-1:0] cnt;
  logic [NREG-1:0]           ld;
  logic                      issue;

  // Register 0 is never written, so its entry is permanently idle; this also
  // makes a zero source address hazard-free without a separate check.
  assign cnt[0] = '0;
  assign ld[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    hazard_sb_entry #(.WB_LAT(WB_LAT), .CNTW(CNTW)) u_entry (
      .clk     (clk),
      .rst     (rst),
      .load    (issue && (id_wr_addr == AW'(i))),
      .load_ld (id_is_load),
      .cnt     (cnt[i]),
      .ld      (ld[i])
    );
  end

  logic         rs_used, rt_used;
  logic         rs_busy, rt_busy;
  logic         haz_load_use, haz_branch, haz_jr;
  stall_cause_t cause;

  assign rs_used = id_use_rs | id_jr;
  assign rt_used = id_use_rt;
  assign rs_busy = rs_used && (cnt[id_rs] != '0);
  assign rt_busy = rt_used && (cnt[id_rt] != '0);

  // A load is still in EX exactly when its counter has not yet moved off WB_LAT.
  assign haz_load_use = (rs_used && ld[id_rs] && (cnt[id_rs] == LAT)) ||
                        (rt_used && ld[id_rt] && (cnt[id_rt] == LAT));
  assign haz_branch   = id_branch && (rs_busy || rt_busy);
  assign haz_jr       = id_jr && (cnt[id_rs] != '0);

  assign stall = id_valid && !id_flush && (haz_load_use || haz_branch || haz_jr);
  assign issue = id_valid && !stall && !id_flush && id_wr_en && (id_wr_addr != '0);

  // NOTE: default assignment first, so no latch is inferred for cause.
  always_comb begin
    cause = CAUSE_NONE;
    if (stall) begin
      if (haz_load_use)    cause = CAUSE_LOAD_USE;
      else if (haz_branch) cause = CAUSE_BRANCH;
      else                 cause = CAUSE_JR;
    end
  end

  assign stall_cause = cause;

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                        perf_q <= '0;
    else if (stall && perf_q != '1) perf_q <= perf_q + 1'b1;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, load-use, branch, jr, priority,
// $0 destinations, WAW reload, flush and mid-stall reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        id_branch, id_jr;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_load;
  logic        id_flush;
  logic        stall;
  logic [1:0]  stall_cause;
  logic [15:0] perf_stall_cnt;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_branch      (id_branch),
    .id_jr          (id_jr),
    .id_wr_en       (id_wr_en),
    .id_wr_addr     (id_wr_addr),
    .id_is_load     (id_is_load),
    .id_flush       (id_flush),
    .stall          (stall),
    .stall_cause    (stall_cause),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("check %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_stall(input string tag, input int s, input int c);
    check({tag, ".stall"}, 32'(stall), 32'(s));
    check({tag, ".cause"}, 32'(stall_cause), 32'(c));
  endtask

  // Drives one ID-stage instruction; fields in port order.
  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br, input logic jr,
                       input logic we, input logic [4:0] wa, input logic isld,
                       input logic fl);
    id_valid   = v;   id_rs      = rs;  id_rt     = rt;
    id_use_rs  = urs; id_use_rt  = urt; id_branch = br;
    id_jr      = jr;  id_wr_en   = we;  id_wr_addr = wa;
    id_is_load = isld; id_flush  = fl;
  endtask

  initial begin
    rst = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    expect_stall("reset", 0, 0);
    check("reset.perf", 32'(perf_stall_cnt), 0);

    // add $9 ; beq $9,$0 : three branch-operand stall cycles
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); #1;
    expect_stall("add9", 0, 0);
    @(negedge clk); instr(1, 9, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1; expect_stall("beq9", 1, 2);
      @(negedge clk);
    end
    #1; expect_stall("beq9.go", 0, 0);

    // jal ; jr $31 : three jr-operand stall cycles
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0); #1;
    expect_stall("jal", 0, 0);
    @(negedge clk); instr(1, 31, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1; expect_stall("jr31", 1, 3);
      @(negedge clk);
    end
    #1; expect_stall("jr31.go", 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf6", 32'(perf_stall_cnt), 6);
`else
    check("perf_tied", 32'(perf_stall_cnt), 0);
`endif

    // jr $4 with $4 idle
    @(negedge clk); instr(1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
    expect_stall("jr4", 0, 0);

    // lw $5 ; beq $5 : load-use wins first, then branch for two cycles
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0); #1;
    expect_stall("lw5", 0, 0);
    @(negedge clk); instr(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0); #1;
    expect_stall("beq5.c0", 1, 1);
    @(negedge clk); #1; expect_stall("beq5.c1", 1, 2);
    @(negedge clk); #1; expect_stall("beq5.c2", 1, 2);
    @(negedge clk); #1; expect_stall("beq5.go", 0, 0);

    // lw $0 then readers of $0 never stall
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); #1;
    expect_stall("lw0", 0, 0);
    @(negedge clk); instr(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0); #1;
    expect_stall("beq0", 0, 0);
    @(negedge clk); instr(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0); #1;
    expect_stall("jr0", 0, 0);

    // lw $8 ; add $10,$8,$9 : exactly one load-use stall
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 8, 1, 0); #1;
    expect_stall("lw8", 0, 0);
    @(negedge clk); instr(1, 8, 9, 1, 1, 0, 0, 1, 10, 0, 0); #1;
    expect_stall("add.lu", 1, 1);
    @(negedge clk); #1; expect_stall("add.go", 0, 0);

    // WAW: add $3 twice, reload restarts the countdown -> three branch stalls
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); #1;
    expect_stall("add3a", 0, 0);
    @(negedge clk); #1; expect_stall("add3b", 0, 0);
    @(negedge clk); instr(1, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1; expect_stall("waw.beq3", 1, 2);
      @(negedge clk);
    end
    #1; expect_stall("waw.go", 0, 0);

    // Flush: hazard suppressed, $12 not loaded, $7 keeps draining
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0); #1;
    expect_stall("lw7", 0, 0);
    @(negedge clk); instr(1, 7, 0, 1, 0, 0, 0, 1, 12, 0, 1); #1;
    expect_stall("flush", 0, 0);
    @(negedge clk); instr(1, 12, 7, 1, 1, 1, 0, 0, 0, 0, 0); #1;
    expect_stall("postflush.c0", 1, 2);
    @(negedge clk); #1; expect_stall("postflush.c1", 1, 2);
    @(negedge clk); #1; expect_stall("postflush.go", 0, 0);

    // Reset pulse in the middle of a branch stall
    @(negedge clk); instr(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); #1;
    expect_stall("rst.add9", 0, 0);
    @(negedge clk); instr(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0); #1;
    expect_stall("rst.beq9", 1, 2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    expect_stall("rst.after", 0, 0);
    check("rst.perf", 32'(perf_stall_cnt), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register-address width; register count NREG = 2**AW.
REQ-002 SHALL have parameter WB_LAT, default 3, meaning cycles from ID issue until the result is in the register file (EX, MEM, WB).
REQ-003 SHALL have parameter CW, default 16, meaning performance-counter width.
REQ-004 SHALL have ports:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  id_valid  in  1  valid instruction in ID
  id_rs, id_rt  in  AW  source register addresses
  id_use_rs, id_use_rt  in  1  the source is actually read
  id_branch  in  1  branch resolved in ID; needs final operand values
  id_jr  in  1  jr; needs final rs value
  id_wr_en  in  1  instruction writes a register (jal included)
  id_wr_addr  in  AW  destination (jal drives 31)
  id_is_load  in  1  destination produced by a load
  id_flush  in  1  ID instruction squashed this cycle
  stall  out  1  hold PC and IF/ID, bubble into EX
  stall_cause  out  2  0 none, 1 load-use, 2 branch operand, 3 jr operand
  perf_stall_cnt  out  CW  stall-cycle count (macro only)

Function
REQ-005 SHALL keep one scoreboard entry per register: cnt (width clog2(WB_LAT+1)) and flag ld.
REQ-006 SHALL define issue = id_valid & ~stall & ~id_flush & id_wr_en & (id_wr_addr != 0).
REQ-007 On issue, SHALL load cnt[id_wr_addr] = WB_LAT and ld[id_wr_addr] = id_is_load on the next edge.
REQ-008 Each cycle, SHALL decrement every nonzero cnt not being loaded; when cnt reaches 0, SHALL clear ld.
REQ-009 Issue to a register whose cnt is nonzero (WAW) SHALL reload that register; reload takes priority over decrement.
REQ-010 Register 0 SHALL never be busy; a source address of 0 SHALL never cause a stall.
REQ-011 A source is "used" when id_use_rs/id_use_rt is set; id_jr implies rs is used.
REQ-012 Load-use hazard: a used source with ld=1 and cnt=WB_LAT (producing load in EX).
REQ-013 Branch hazard: id_branch and a used source with cnt>0 (no forwarding into ID).
REQ-014 Jr hazard: id_jr and cnt[rs]>0; this covers jal followed by jr $31 until the jal retires.
REQ-015 stall SHALL be combinational: id_valid & ~id_flush & (any hazard); stall_cause priority SHALL be load-use > branch > jr, and 0 when stall=0.
REQ-016 A stalled instruction SHALL not issue; its hazard is re-evaluated every cycle until the producer's cnt drains. The maximum stall length is WB_LAT cycles.
REQ-017 id_flush SHALL suppress stall and issue in the same cycle; entries already issued SHALL keep counting.

Reset
REQ-018 While rst=1 at an edge, SHALL clear all cnt and ld, and perf_stall_cnt; stall and stall_cause SHALL read 0 from the first cycle after reset.
REQ-019 Reset asserted mid-stall SHALL drop all pending hazards; no issue occurs during a reset cycle.

Configuration
REQ-020 With HAZARD_PERF_CNT_EN defined, SHALL increment perf_stall_cnt on each cycle with stall=1, saturating at 2**CW-1.
REQ-021 Without HAZARD_PERF_CNT_EN, perf_stall_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-022 SHALL place the stall_cause encoding (NONE, LOAD_USE, BRANCH, JR) and the default AW/WB_LAT/CW values in shared package hazard_pkg.
REQ-023 SHALL use one sub-module, hazard_sb_entry (cnt, ld, load/decrement logic), instantiated NREG-1 times; register 0 is hardwired idle.

Verification
REQ-024 lw $8; next add uses $8 -> stall=1, cause=1 for exactly 1 cycle, then 0.
REQ-025 add $9; next beq $9,$0 -> stall=1, cause=2 for 3 cycles (WB_LAT=3), then 0.
REQ-026 jal (wr 31); next jr $31 -> stall=1, cause=3 for 3 cycles; jr with rs=$4 idle -> no stall.
REQ-027 lw $5 then beq $5 -> cause=1 in the first cycle (priority), cause=2 for the next 2 cycles; writes to $0 -> never stall.
REQ-028 id_flush=1 with a hazard present -> stall=0 and no entry loaded; rst pulse during a branch stall -> stall=0 next cycle; with the macro, 6 stall cycles -> perf_stall_cnt=6.
